// File: rtl/sha256_cfu_pkg.sv
// Shared types and constants for the SHA-256 sigma CFU path: function encoding,
// rotate/shift amounts and the response entry carried through the result FIFO.
package sha256_cfu_pkg;

  typedef enum logic [1:0] {
    SUM0 = 2'd0,
    SUM1 = 2'd1,
    SIG0 = 2'd2,
    SIG1 = 2'd3
  } sigma_func_e;

  localparam int SUM0_R0 = 2;
  localparam int SUM0_R1 = 13;
  localparam int SUM0_R2 = 22;
  localparam int SUM1_R0 = 6;
  localparam int SUM1_R1 = 11;
  localparam int SUM1_R2 = 25;
  localparam int SIG0_R0 = 7;
  localparam int SIG0_R1 = 18;
  localparam int SIG0_SH = 3;
  localparam int SIG1_R0 = 17;
  localparam int SIG1_R1 = 19;
  localparam int SIG1_SH = 10;

  // Wide enough for the largest supported requester count (4).
  localparam int ID_MAX_W = 2;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [31:0]         data;
  } resp_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_sigma_arbiter_if.sv
// Requester and response bundle between CFU dispatch ports and the shared
// sigma arbiter. The arbiter uses the slave view; the dispatch side uses master.
interface sha256_sigma_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][1:0]  req_func;
  logic [N_REQ-1:0][31:0] req_data;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [31:0]            resp_data;
  logic [15:0]            ops_done;

  modport slave (
    input  req_valid, req_func, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, ops_done
  );

  modport master (
    output req_valid, req_func, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, ops_done
  );

endinterface

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 sigma unit: selects one of the four message-schedule /
// compression sigma functions on the full 32-bit operand.
module sha256_sigma
  import sha256_cfu_pkg::*;
(
  input  logic [1:0]  func,
  input  logic [31:0] data,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    unique case (sigma_func_e'(func))
      SUM0: result = ror32(data, SUM0_R0) ^ ror32(data, SUM0_R1) ^ ror32(data, SUM0_R2);
      SUM1: result = ror32(data, SUM1_R0) ^ ror32(data, SUM1_R1) ^ ror32(data, SUM1_R2);
      SIG0: result = ror32(data, SIG0_R0) ^ ror32(data, SIG0_R1) ^ (data >> SIG0_SH);
      SIG1: result = ror32(data, SIG1_R0) ^ ror32(data, SIG1_R1) ^ (data >> SIG1_SH);
    endcase
  end

endmodule

// File: rtl/sha256_sigma_arbiter.sv
// Round-robin arbiter sharing one sigma unit between N_REQ requesters; results
// are queued with their port id in a small FIFO and leave in acceptance order.
module sha256_sigma_arbiter
  import sha256_cfu_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sha256_sigma_arbiter_if.slave  bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      ops_done_q, ops_done_d;
  resp_t            mem_q [FIFO_DEPTH];
  resp_t            mem_d [FIFO_DEPTH];

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic             space;
  logic             push;
  logic             pop;
  logic [31:0]      sigma_res;
  resp_t            head;

  // Scan from rr_ptr upward (mod N_REQ); the first valid port wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // Space is judged on the start-of-cycle count only, so a pop never frees a
  // slot for a same-cycle push and resp_ready cannot reach req_ready.
  assign space = (count_q < CNT_W'(FIFO_DEPTH));
  assign push  = grant_vld & space;
  assign pop   = (count_q != '0) & bus.resp_ready;

  always_comb begin
    bus.req_ready = '0;
    if (push && !rst) bus.req_ready[grant_idx] = 1'b1;
  end

  sha256_sigma u_sigma (
    .func   (bus.req_func[grant_idx]),
    .data   (bus.req_data[grant_idx]),
    .result (sigma_res)
  );

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    ops_done_d = ops_done_q + 16'(pop);
    if (push) begin
      rr_ptr_d        = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      mem_d[wr_ptr_q] = '{id: ID_MAX_W'(grant_idx), data: sigma_res};
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ops_done_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ops_done_q <= ops_done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.resp_valid = (count_q != '0);
  assign bus.resp_id    = ID_W'(head.id);
  assign bus.resp_data  = head.data;
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_sha256_sigma_arbiter.sv
// Directed bench for sha256_sigma_arbiter (N_REQ=2, FIFO_DEPTH=2) with
// hand-computed sigma results, arbitration order and FIFO backpressure.
module tb_sha256_sigma_arbiter;

  localparam int N_REQ      = 2;
  localparam int FIFO_DEPTH = 2;

  localparam logic [31:0] R_S0_1 = 32'h40080400;
  localparam logic [31:0] R_S1_1 = 32'h04200080;
  localparam logic [31:0] R_s0_1 = 32'h02004000;
  localparam logic [31:0] R_s1_1 = 32'h0000A000;
  localparam logic [31:0] R_S0_M = 32'h20040200;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sha256_sigma_arbiter_if #(.N_REQ(N_REQ)) bus_if ();

  sha256_sigma_arbiter #(.N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input logic [1:0] f, input logic [31:0] d);
    bus_if.req_valid[p] = v;
    bus_if.req_func[p]  = f;
    bus_if.req_data[p]  = d;
  endtask

  // One isolated request on port p, then pop it; ops_done must advance by one.
  task automatic single(input string tag, input int p, input logic [1:0] f,
                        input logic [31:0] d, input logic [31:0] exp, input int done_before);
    logic [1:0] rdy_exp;
    rdy_exp = '0;
    rdy_exp[p] = 1'b1;
    drive(p, 1'b1, f, d);
    #1;
    chk({tag, "_ready"}, 32'(bus_if.req_ready), 32'(rdy_exp));
    step();
    drive(p, 1'b0, 2'd0, 32'd0);
    chk({tag, "_valid"}, 32'(bus_if.resp_valid), 32'd1);
    chk({tag, "_data"}, bus_if.resp_data, exp);
    chk({tag, "_id"}, 32'(bus_if.resp_id), 32'(p));
    bus_if.resp_ready = 1'b1;
    step();
    bus_if.resp_ready = 1'b0;
    chk({tag, "_empty"}, 32'(bus_if.resp_valid), 32'd0);
    chk({tag, "_ops"}, 32'(bus_if.ops_done), 32'(done_before + 1));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_if.req_valid  = '0;
    bus_if.req_func   = '0;
    bus_if.req_data   = '0;
    bus_if.resp_ready = 1'b0;
    @(negedge clk);

    // Reset state; a request during reset must not be offered ready.
    drive(0, 1'b1, 2'd0, 32'd1);
    #1;
    chk("rst_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus_if.resp_id), 32'd0);
    chk("rst_resp_data", bus_if.resp_data, 32'd0);
    chk("rst_ops", 32'(bus_if.ops_done), 32'd0);
    drive(0, 1'b0, 2'd0, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Individual functions; alternating ports leave rr_ptr at 0 afterwards.
    single("s0_p0", 0, 2'd0, 32'h00000001, R_S0_1, 0);
    single("s1_p1", 1, 2'd1, 32'h00000001, R_S1_1, 1);
    single("sg0_p0", 0, 2'd2, 32'h00000001, R_s0_1, 2);
    single("sg1_p1", 1, 2'd3, 32'h00000001, R_s1_1, 3);
    single("s0msb_p0", 0, 2'd0, 32'h80000000, R_S0_M, 4);
    single("s0msb_p1", 1, 2'd0, 32'h80000000, R_S0_M, 5);

    // Contention with a draining consumer: grants alternate 0,1,0,1,...
    drive(0, 1'b1, 2'd0, 32'd1);
    drive(1, 1'b1, 2'd1, 32'd1);
    bus_if.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_ready", 32'(bus_if.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk("cont_valid", 32'(bus_if.resp_valid), 32'd1);
        chk("cont_id", 32'(bus_if.resp_id), 32'((k - 1) % 2));
        chk("cont_data", bus_if.resp_data, ((k - 1) % 2 == 0) ? R_S0_1 : R_S1_1);
      end
      step();
    end
    drive(0, 1'b0, 2'd0, 32'd0);
    drive(1, 1'b0, 2'd0, 32'd0);
    chk("cont_last_id", 32'(bus_if.resp_id), 32'd1);
    chk("cont_last_data", bus_if.resp_data, R_S1_1);
    step();
    chk("cont_drained", 32'(bus_if.resp_valid), 32'd0);
    chk("cont_ops", 32'(bus_if.ops_done), 32'd12);

    // Backpressure: exactly FIFO_DEPTH accepts, then one pop lets one more in.
    bus_if.resp_ready = 1'b0;
    drive(0, 1'b1, 2'd2, 32'd1);
    drive(1, 1'b1, 2'd3, 32'd1);
    #1;
    chk("bp_acc0", 32'(bus_if.req_ready), 32'd1);
    step();
    chk("bp_acc1", 32'(bus_if.req_ready), 32'd2);
    step();
    chk("bp_full_ready", 32'(bus_if.req_ready), 32'd0);
    chk("bp_head0_id", 32'(bus_if.resp_id), 32'd0);
    chk("bp_head0_data", bus_if.resp_data, R_s0_1);
    bus_if.resp_ready = 1'b1;
    #1;
    chk("bp_no_passthru", 32'(bus_if.req_ready), 32'd0);
    step();
    bus_if.resp_ready = 1'b0;
    #1;
    chk("bp_resume", 32'(bus_if.req_ready), 32'd1);
    chk("bp_head1_id", 32'(bus_if.resp_id), 32'd1);
    chk("bp_head1_data", bus_if.resp_data, R_s1_1);
    step();
    chk("bp_full_again", 32'(bus_if.req_ready), 32'd0);
    drive(0, 1'b0, 2'd0, 32'd0);
    drive(1, 1'b0, 2'd0, 32'd0);
    bus_if.resp_ready = 1'b1;
    step();
    chk("bp_head2_id", 32'(bus_if.resp_id), 32'd0);
    chk("bp_head2_data", bus_if.resp_data, R_s0_1);
    step();
    chk("bp_drained", 32'(bus_if.resp_valid), 32'd0);
    chk("bp_ops", 32'(bus_if.ops_done), 32'd15);

    // Reset with the FIFO full (rr_ptr is 1 here, so fill order is 1 then 0).
    bus_if.resp_ready = 1'b0;
    drive(0, 1'b1, 2'd0, 32'd1);
    drive(1, 1'b1, 2'd1, 32'd1);
    step();
    step();
    chk("rf_full", 32'(bus_if.req_ready), 32'd0);
    chk("rf_valid_pre", 32'(bus_if.resp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rf_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rf_ops", 32'(bus_if.ops_done), 32'd0);
    chk("rf_data", bus_if.resp_data, 32'd0);
    chk("rf_ready", 32'(bus_if.req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rf_first_grant", 32'(bus_if.req_ready), 32'd1);
    step();
    drive(0, 1'b0, 2'd0, 32'd0);
    drive(1, 1'b0, 2'd0, 32'd0);
    chk("rf_post_id", 32'(bus_if.resp_id), 32'd0);
    chk("rf_post_data", bus_if.resp_data, R_S0_1);
    bus_if.resp_ready = 1'b1;
    step();
    bus_if.resp_ready = 1'b0;
    chk("rf_post_empty", 32'(bus_if.resp_valid), 32'd0);
    chk("rf_post_ops", 32'(bus_if.ops_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
